// File: rtl/tsf_timer_pkg.sv
// Shared xpu timing constants: TSF width and default clk-per-microsecond ratio.
package tsf_timer_pkg;
  localparam int TSF_W          = 64;
  localparam int TSF_CLK_PER_US = 100;
endpackage

// File: rtl/tsf_timer.sv
// Free-running 64-bit microsecond TSF counter with 1 MHz strobe, load, signed
// drift adjust, pause and atomic snapshot.
module tsf_timer
  import tsf_timer_pkg::*;
#(
  parameter int CLK_PER_US = TSF_CLK_PER_US
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tsf_run,
  input  logic             tsf_load_en,
  input  logic [31:0]      tsf_load_val_low,
  input  logic [31:0]      tsf_load_val_high,
  input  logic             tsf_adj_en,
  input  logic [15:0]      tsf_adj,
  input  logic             tsf_snap_req,
  output logic [TSF_W-1:0] tsf_runtime_val,
  output logic [TSF_W-1:0] tsf_snap_val,
  output logic             tsf_pulse_1M
);

  localparam int PW = (CLK_PER_US < 2) ? 1 : $clog2(CLK_PER_US);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_US - 1);

  generate
    if (CLK_PER_US < 2) begin : g_bad_param
      $error("tsf_timer: CLK_PER_US must be >= 2");
    end
  endgenerate

  logic [PW-1:0]    presc;
  logic             tick;
  logic [TSF_W-1:0] adj_ext;
  logic [TSF_W-1:0] tsf_next;

  assign tick    = tsf_run && (presc == PRESC_MAX);
  assign adj_ext = tsf_adj_en ? {{(TSF_W-16){tsf_adj[15]}}, tsf_adj} : '0;
  // adjust and tick fold into one carry chain
  assign tsf_next = tsf_runtime_val + adj_ext + {{(TSF_W-1){1'b0}}, tick};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc           <= '0;
      tsf_runtime_val <= '0;
      tsf_snap_val    <= '0;
      tsf_pulse_1M    <= 1'b0;
    end else begin
      // snapshot takes the pre-edge value, independent of load/adjust/tick
      if (tsf_snap_req)
        tsf_snap_val <= tsf_runtime_val;
      if (tsf_load_en) begin
        tsf_runtime_val <= {tsf_load_val_high, tsf_load_val_low};
        presc           <= '0;
        tsf_pulse_1M    <= 1'b0;
      end else begin
        tsf_runtime_val <= tsf_next;
        tsf_pulse_1M    <= tick;
        if (tsf_run)
          presc <= tick ? '0 : presc + 1'b1;
      end
    end
  end

endmodule
